// File: rtl/hitmark_pkg.sv
// Shared types and constants for the hitmark sprite sequencer.
package hitmark_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SHOW,
        BLINK
    } hm_state_t;

    localparam int HM_BLINK_BIT = 2;
    localparam int COORD_W      = 10;

endpackage

// File: rtl/hitmark_ctrl.sv
// Hitmark sprite sequencer: latches a hit, shows the sprite for a fixed number of
// frames, blinks it, and drives the sprite RAM read address from the pixel scan.
//
//  state | meaning
//  IDLE  | nothing displayed, waiting for a hit
//  ARM   | hit latched, waiting for the next frame boundary
//  SHOW  | sprite drawn solid, counting frames
//  BLINK | sprite toggles visibility every 4 frames, counting frames
module hitmark_ctrl
    import hitmark_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 4,
    parameter int SPRITE_W     = 32,
    parameter int SPRITE_H     = 32,
    parameter int H_PIX        = 640,
    parameter int V_PIX        = 480,
    parameter int SHOW_FRAMES  = 30,
    parameter int BLINK_FRAMES = 16,
    parameter int TRANSPARENT  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hit,
    input  logic [COORD_W-1:0]    hit_x,
    input  logic [COORD_W-1:0]    hit_y,
    input  logic                  refr_tick,
    input  logic [COORD_W-1:0]    x,
    input  logic [COORD_W-1:0]    y,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [ADDR_WIDTH-1:0] ram_addr_r,
    output logic                  hm_on,
    output logic [DATA_WIDTH-1:0] hm_rgb,
    output logic                  busy
);

    localparam int SW_B  = $clog2(SPRITE_W);
    localparam int SH_B  = $clog2(SPRITE_H);
    localparam int FMAX  = (SHOW_FRAMES > BLINK_FRAMES) ? SHOW_FRAMES : BLINK_FRAMES;
    localparam int CNT_W = ($clog2(FMAX) > HM_BLINK_BIT) ? $clog2(FMAX) : HM_BLINK_BIT + 1;

    localparam logic [COORD_W-1:0] X_LIM     = COORD_W'(H_PIX - SPRITE_W);
    localparam logic [COORD_W-1:0] Y_LIM     = COORD_W'(V_PIX - SPRITE_H);
    localparam logic [CNT_W-1:0]   SHOW_LAST = CNT_W'(SHOW_FRAMES - 1);
    localparam logic [CNT_W-1:0]   BLNK_LAST = CNT_W'(BLINK_FRAMES - 1);

    hm_state_t          r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_frame_cnt, w_frame_cnt_nxt;
    logic [COORD_W-1:0] r_pend_x, r_pend_y;
    logic [COORD_W-1:0] r_ox, r_oy;
    logic               r_in_box_d, r_vis_d;

    logic               w_load_origin;
    logic               w_visible;
    logic               w_in_box;
    logic [COORD_W-1:0] w_clamp_x, w_clamp_y;
    logic [SW_B-1:0]    w_dx;
    logic [SH_B-1:0]    w_dy;

    assign w_clamp_x = (hit_x > X_LIM) ? X_LIM : hit_x;
    assign w_clamp_y = (hit_y > Y_LIM) ? Y_LIM : hit_y;

    always_comb begin
        w_state_nxt     = r_state;
        w_frame_cnt_nxt = r_frame_cnt;
        w_load_origin   = 1'b0;
        w_visible       = 1'b0;
        case (r_state)
            IDLE: ;
            ARM: begin
                if (refr_tick) begin
                    w_state_nxt     = SHOW;
                    w_frame_cnt_nxt = '0;
                    w_load_origin   = 1'b1;
                end
            end
            SHOW: begin
                w_visible = 1'b1;
                if (refr_tick) begin
                    if (r_frame_cnt == SHOW_LAST) begin
                        w_state_nxt     = BLINK;
                        w_frame_cnt_nxt = '0;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                    end
                end
            end
            BLINK: begin
                w_visible = ~r_frame_cnt[HM_BLINK_BIT];
                if (refr_tick) begin
                    if (r_frame_cnt == BLNK_LAST) begin
                        w_state_nxt     = IDLE;
                        w_frame_cnt_nxt = '0;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // A hit overrides any tick in the same cycle; the tick is simply dropped.
        if (hit) begin
            w_state_nxt     = ARM;
            w_frame_cnt_nxt = '0;
            w_load_origin   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_frame_cnt <= '0;
            r_pend_x    <= '0;
            r_pend_y    <= '0;
            r_ox        <= '0;
            r_oy        <= '0;
            r_in_box_d  <= 1'b0;
            r_vis_d     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            if (hit) begin
                r_pend_x <= w_clamp_x;
                r_pend_y <= w_clamp_y;
            end
            if (w_load_origin) begin
                r_ox <= r_pend_x;
                r_oy <= r_pend_y;
            end
            r_in_box_d <= w_in_box;
            r_vis_d    <= w_visible;
        end
    end

    // Upper bound compared one bit wider so ox + SPRITE_W cannot wrap.
    assign w_in_box = (x >= r_ox)
                    & ({1'b0, x} < ({1'b0, r_ox} + (COORD_W + 1)'(SPRITE_W)))
                    & (y >= r_oy)
                    & ({1'b0, y} < ({1'b0, r_oy} + (COORD_W + 1)'(SPRITE_H)));

    assign w_dx = x[SW_B-1:0] - r_ox[SW_B-1:0];
    assign w_dy = y[SH_B-1:0] - r_oy[SH_B-1:0];

    assign ram_addr_r = w_in_box ? ADDR_WIDTH'({w_dy, w_dx}) : '0;

    assign hm_on  = r_in_box_d & r_vis_d & (ram_dout != DATA_WIDTH'(TRANSPARENT));
    assign hm_rgb = hm_on ? ram_dout : '0;
    assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_hitmark_ctrl.sv
// Directed bench for hitmark_ctrl with a one-cycle-latency sprite RAM model
// preloaded so that each word equals the low nibble of its address.
module tb_hitmark_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       hit;
    logic [9:0] hit_x, hit_y;
    logic       refr_tick;
    logic [9:0] x, y;
    logic [3:0] ram_dout;
    logic [9:0] ram_addr_r;
    logic       hm_on;
    logic [3:0] hm_rgb;
    logic       busy;

    logic [3:0] mem [1024];

    int n_vec = 0;
    int n_err = 0;

    hitmark_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .hit        (hit),
        .hit_x      (hit_x),
        .hit_y      (hit_y),
        .refr_tick  (refr_tick),
        .x          (x),
        .y          (y),
        .ram_dout   (ram_dout),
        .ram_addr_r (ram_addr_r),
        .hm_on      (hm_on),
        .hm_rgb     (hm_rgb),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) ram_dout <= mem[ram_addr_r];

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        refr_tick = 1'b1;
        step();
        refr_tick = 1'b0;
    endtask

    task automatic pulse_hit(input logic [9:0] hx, input logic [9:0] hy, input logic with_tick);
        hit       = 1'b1;
        hit_x     = hx;
        hit_y     = hy;
        refr_tick = with_tick;
        step();
        hit       = 1'b0;
        refr_tick = 1'b0;
    endtask

    task automatic probe(input string tag, input logic [9:0] px, input logic [9:0] py,
                         input int exp_addr, input logic exp_on);
        logic [31:0] ea;
        ea = 32'(exp_addr);
        x  = px;
        y  = py;
        #2;
        chk_val({tag, ".addr"}, 32'(ram_addr_r), ea);
        step();
        #2;
        chk_val({tag, ".on"}, 32'(hm_on), 32'(exp_on));
        chk_val({tag, ".rgb"}, 32'(hm_rgb), exp_on ? 32'(ea[3:0]) : 32'd0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse_tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 4'(i);
        reset = 1'b1; hit = 1'b0; hit_x = '0; hit_y = '0;
        refr_tick = 1'b0; x = '0; y = '0;

        // reset and idle
        repeat (3) step();
        #2;
        chk_val("rst.on", 32'(hm_on), 0);
        chk_val("rst.busy", 32'(busy), 0);
        chk_val("rst.addr", 32'(ram_addr_r), 0);
        reset = 1'b0;
        step();
        for (int f = 0; f < 2; f++) begin
            pulse_tick();
            probe("idle0", 10'd0, 10'd0, 0, 1'b0);
            probe("idle1", 10'd300, 10'd300, 0, 1'b0);
            chk_val("idle.busy", 32'(busy), 0);
        end

        // basic hit
        pulse_hit(10'd100, 10'd50, 1'b0);
        chk_val("hit.busy", 32'(busy), 1);
        probe("arm", 10'd105, 10'd52, 0, 1'b0);
        pulse_tick();
        probe("show69", 10'd105, 10'd52, 69, 1'b1);
        probe("transp", 10'd100, 10'd52, 64, 1'b0);
        probe("left", 10'd99, 10'd50, 0, 1'b0);
        probe("corner", 10'd131, 10'd81, 1023, 1'b1);
        probe("right", 10'd132, 10'd50, 0, 1'b0);

        // lifetime: 29 more SHOW ticks, then 16 BLINK ticks
        for (int i = 1; i < 30; i++) begin
            pulse_tick();
            probe("show", 10'd105, 10'd52, 69, 1'b1);
        end
        pulse_tick();
        for (int k = 0; k < 16; k++) begin
            probe("blink", 10'd105, 10'd52, 69, ((k >> 2) & 1) == 0);
            chk_val("blink.busy", 32'(busy), 1);
            pulse_tick();
        end
        chk_val("end.busy", 32'(busy), 0);
        probe("end", 10'd105, 10'd52, 69, 1'b0);

        // clamp and edges
        pulse_hit(10'd630, 10'd470, 1'b0);
        pulse_tick();
        probe("clamp.l", 10'd607, 10'd448, 0, 1'b0);
        probe("clamp.o", 10'd609, 10'd449, 33, 1'b1);
        probe("clamp.br", 10'd639, 10'd479, 1023, 1'b1);
        probe("clamp.x", 10'd640, 10'd460, 0, 1'b0);
        probe("clamp.y", 10'd620, 10'd480, 0, 1'b0);
        probe("clamp.z", 10'd0, 10'd0, 0, 1'b0);

        // retrigger on the same cycle as a tick during BLINK
        ticks(30);
        ticks(5);
        pulse_hit(10'd200, 10'd200, 1'b1);
        chk_val("retrig.busy", 32'(busy), 1);
        probe("retrig.old", 10'd639, 10'd479, 1023, 1'b0);
        probe("retrig.new", 10'd205, 10'd202, 0, 1'b0);
        pulse_tick();
        probe("retrig.show", 10'd205, 10'd202, 69, 1'b1);
        ticks(29);
        probe("retrig.c29", 10'd205, 10'd202, 69, 1'b1);
        ticks(1);
        probe("retrig.b0", 10'd205, 10'd202, 69, 1'b1);
        ticks(4);
        probe("retrig.b4", 10'd205, 10'd202, 69, 1'b0);

        // async reset in the middle of SHOW
        pulse_hit(10'd200, 10'd200, 1'b0);
        pulse_tick();
        probe("pre_rst", 10'd205, 10'd202, 69, 1'b1);
        chk_val("pre_rst.on2", 32'(hm_on), 1);
        pulse_hit(10'd300, 10'd300, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        chk_val("arst.on", 32'(hm_on), 0);
        chk_val("arst.rgb", 32'(hm_rgb), 0);
        chk_val("arst.busy", 32'(busy), 0);
        chk_val("arst.addr", 32'(ram_addr_r), 0);
        repeat (2) step();
        reset = 1'b0;
        step();
        pulse_tick();
        chk_val("post_rst.busy", 32'(busy), 0);
        probe("post_rst", 10'd5, 10'd2, 69, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
